telemetry_rx: RTL

Receive side of the eBike telemetry link. Deserializes the 8N1 UART stream that the telemetry transmitter drives on TX, frames the 8-byte packet (0xAA, 0x55, then battery voltage, average current and average torque as high/low byte pairs), and presents the three 12-bit quantities with a one-cycle valid strobe. It sits on the bench and display side of the link, and serves as the loopback checker for sensor conditioning.

---
 rtl/telemetry_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/telemetry_rx.sv
// Telemetry link receiver: 8N1 UART deserializer feeding a framer for the
// AA 55 + three 12-bit value packet, with one-cycle vld / frm_err / pkt_err strobes.
module telemetry_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        vld,
  output logic        frm_err,
  output logic        pkt_err
);
  localparam logic [11:0] FULL_CNT = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_CNT = 12'(BAUD_DIV / 2 - 1);
  localparam logic [7:0]  SYNC_A   = 8'hAA;
  localparam logic [7:0]  SYNC_B   = 8'h55;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;
  typedef enum logic [1:0] {SYNC1, SYNC2, PAYLOAD} pktState_t;

  rxState_t    r_rxState, w_rxNext;
  pktState_t   r_pktState, w_pktNext;
  logic        r_rxMeta, r_rxs, r_rxPrev;
  logic [11:0] r_baudCnt;
  logic [2:0]  r_bitCnt;
  logic [7:0]  r_shift;
  logic        r_byteRdy, r_frmErr;
  logic [2:0]  r_idx;
  logic [11:0] r_shBatt, r_shCurr;
  logic [3:0]  r_shTorqueHi;
  logic [11:0] r_battV, r_avgCurr, r_avgTorque;
  logic        r_vld, r_pktErr;
  logic        w_tick, w_fall, w_highBad, w_accept, w_vldNext, w_pktErrNext;

  assign w_tick = (r_baudCnt == 12'd0);
  assign w_fall = r_rxPrev & ~r_rxs;

  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      IDLE:    if (w_fall) w_rxNext = START;
      START:   if (w_tick) w_rxNext = r_rxs ? IDLE : DATA;
      DATA:    if (w_tick && r_bitCnt == 3'd7) w_rxNext = STOP;
      STOP:    if (w_tick) w_rxNext = IDLE;
      default: w_rxNext = IDLE;
    endcase
  end

  // Synchronizer resets high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxMeta  <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxPrev  <= 1'b1;
      r_rxState <= IDLE;
      r_baudCnt <= 12'd0;
      r_bitCnt  <= 3'd0;
      r_shift   <= 8'd0;
      r_byteRdy <= 1'b0;
      r_frmErr  <= 1'b0;
    end else begin
      r_rxMeta  <= RX;
      r_rxs     <= r_rxMeta;
      r_rxPrev  <= r_rxs;
      r_rxState <= w_rxNext;
      if (r_rxState == IDLE) begin
        if (w_fall) r_baudCnt <= HALF_CNT;
      end else if (w_tick) begin
        r_baudCnt <= FULL_CNT;
      end else begin
        r_baudCnt <= r_baudCnt - 12'd1;
      end
      if (r_rxState == START) r_bitCnt <= 3'd0;
      else if (r_rxState == DATA && w_tick) r_bitCnt <= r_bitCnt + 3'd1;
      if (r_rxState == DATA && w_tick) r_shift <= {r_rxs, r_shift[7:1]};
      r_byteRdy <= (r_rxState == STOP) && w_tick && r_rxs;
      r_frmErr  <= (r_rxState == STOP) && w_tick && !r_rxs;
    end
  end

  // Even payload positions are high bytes and may only carry a nibble.
  assign w_highBad = !r_idx[0] && (r_shift[7:4] != 4'd0);
  assign w_accept  = r_byteRdy && (r_pktState == PAYLOAD) && !w_highBad;

  always_comb begin
    w_pktNext    = r_pktState;
    w_vldNext    = 1'b0;
    w_pktErrNext = 1'b0;
    if (r_frmErr) begin
      w_pktNext = SYNC1;
    end else if (r_byteRdy) begin
      case (r_pktState)
        SYNC1: if (r_shift == SYNC_A) w_pktNext = SYNC2;
        SYNC2: begin
          if (r_shift == SYNC_B) w_pktNext = PAYLOAD;
          else if (r_shift != SYNC_A) w_pktNext = SYNC1;
        end
        PAYLOAD: begin
          if (w_highBad) begin
            w_pktErrNext = 1'b1;
            w_pktNext    = SYNC1;
          end else if (r_idx == 3'd5) begin
            w_vldNext = 1'b1;
            w_pktNext = SYNC1;
          end
        end
        default: w_pktNext = SYNC1;
      endcase
    end
  end

  // Shadows absorb partial packets; outputs move only on a complete one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pktState   <= SYNC1;
      r_idx        <= 3'd0;
      r_shBatt     <= 12'd0;
      r_shCurr     <= 12'd0;
      r_shTorqueHi <= 4'd0;
      r_battV      <= 12'd0;
      r_avgCurr    <= 12'd0;
      r_avgTorque  <= 12'd0;
      r_vld        <= 1'b0;
      r_pktErr     <= 1'b0;
    end else begin
      r_pktState <= w_pktNext;
      r_vld      <= w_vldNext;
      r_pktErr   <= w_pktErrNext;
      if (r_byteRdy && r_pktState == SYNC2 && r_shift == SYNC_B) r_idx <= 3'd0;
      else if (w_accept) r_idx <= r_idx + 3'd1;
      if (w_accept) begin
        case (r_idx)
          3'd0:    r_shBatt[11:8] <= r_shift[3:0];
          3'd1:    r_shBatt[7:0]  <= r_shift;
          3'd2:    r_shCurr[11:8] <= r_shift[3:0];
          3'd3:    r_shCurr[7:0]  <= r_shift;
          3'd4:    r_shTorqueHi   <= r_shift[3:0];
          default: ;
        endcase
      end
      if (w_vldNext) begin
        r_battV     <= r_shBatt;
        r_avgCurr   <= r_shCurr;
        r_avgTorque <= {r_shTorqueHi, r_shift};
      end
    end
  end

  assign batt_v     = r_battV;
  assign avg_curr   = r_avgCurr;
  assign avg_torque = r_avgTorque;
  assign vld        = r_vld;
  assign frm_err    = r_frmErr;
  assign pkt_err    = r_pktErr;
endmodule
